uart_rx_os16: RTL

// - UART receive path; consumes the 16x oversample clock (clk_baud_sample) produced by uart_baud on the same clk.
// - Recovers 8N1 frames from asynchronous rxd: start-bit validation, 3-sample majority vote per bit, stop-bit check.
// - Delivers bytes through a valid/ready handshake to the downstream consumer (loopback, FIFO or host logic).

---
 rtl/uart_rx_os16_pkg.sv | 18 +
 rtl/uart_sync2.sv | 23 ++
 rtl/uart_rx_os16.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_rx_os16_pkg.sv
// uart_rx_os16_pkg: shared receiver state encoding, mid-bit sample point and majority vote helper.
package uart_rx_os16_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } rx_state_e;

    localparam int MID_SAMPLE = 8;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for asynchronous inputs with a configurable reset level.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            q_o    <= RST_VAL;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 8N1 UART receiver driven by a 16x oversample strobe, with 3-sample majority vote
// per bit and a valid/ready output handshake.
module uart_rx_os16
    import uart_rx_os16_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_sample,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] CNT_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] SAMP_LO  = TW'(MID_SAMPLE - 1);
    localparam logic [TW-1:0] SAMP_HI  = TW'(MID_SAMPLE + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [2:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 baud_q, rxd_s, tick, bit_end, stop_vote;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk(clk),
        .rst(rst),
        .d_i(rxd),
        .q_o(rxd_s)
    );

    assign tick      = baud_sample & ~baud_q;
    assign bit_end   = tick_cnt_q == CNT_LAST;
    // Stop bit resolves on its last sample, so the third vote input is the live line value.
    assign stop_vote = maj3({samp_q[1:0], rxd_s});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            samp_q      <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            baud_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            samp_q      <= samp_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            baud_q      <= baud_sample;
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        samp_d      = samp_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q & ~rx_ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        if (tick) begin
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
            if (tick_cnt_q >= SAMP_LO && tick_cnt_q <= SAMP_HI) samp_d = {samp_q[1:0], rxd_s};
            case (state_q)
                S_IDLE: begin
                    tick_cnt_d = '0;
                    if (!rxd_s) state_d = S_START;
                end
                S_START: if (bit_end) begin
                    state_d   = maj3(samp_q) ? S_IDLE : S_DATA;
                    bit_cnt_d = '0;
                end
                S_DATA: if (bit_end) begin
                    shift_d   = {maj3(samp_q), shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) state_d = S_STOP;
                end
                S_STOP: if (tick_cnt_q == SAMP_HI) begin
                    tick_cnt_d  = '0;
                    state_d     = stop_vote ? S_IDLE : S_BREAK;
                    frame_err_d = ~stop_vote;
                    overrun_d   = stop_vote & rx_valid_q & ~rx_ready;
                    if (stop_vote && !(rx_valid_q && !rx_ready)) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end
                end
                S_BREAK: begin
                    tick_cnt_d = '0;
                    if (rxd_s) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = frame_err_q;
    assign rx_overrun   = overrun_q;
    assign rx_busy      = state_q != S_IDLE;

endmodule
